pll_lock_reset_seq: RTL and testbench



---
 rtl/pll_seq_pkg.sv | 35 +++
 rtl/sync2_bit.sv | 32 +++
 rtl/pll_lock_reset_seq.sv | 153 +++++++++++++++
 tb/tb_pll_lock_reset_seq.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_seq_pkg.sv
// ---------------------------------------------------------------------------
// pll_seq_pkg
// Shared definitions for the PLL lock / reset sequencer:
//   - state_e       : sequencer states
//   - DEF_*         : default parameter values
//   - cnt_width()   : width of the shared state counter
// ---------------------------------------------------------------------------
package pll_seq_pkg;

    typedef enum logic [2:0] {
        ST_PLL_RST   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_FILTER    = 3'd2,
        ST_RELEASE   = 3'd3,
        ST_RUN       = 3'd4
    } state_e;

    localparam int unsigned DEF_LOCK_CYCLES    = 16;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 1024;
    localparam int unsigned DEF_PLL_RST_CYCLES = 4;
    localparam int unsigned DEF_RELEASE_DELAY  = 8;

    // $clog2 of the largest count plus one spare bit, so the counter can
    // saturate above every terminal value instead of wrapping.
    function automatic int cnt_width(input int unsigned a, input int unsigned b,
                                     input int unsigned c, input int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/sync2_bit.sv
// ---------------------------------------------------------------------------
// sync2_bit
// Two-flop synchroniser for a single asynchronous status bit.
// Ports:
//   clk_i    destination clock
//   rst_n_i  synchronous active-low reset (clears both flops)
//   d_i      asynchronous input
//   q_o      synchronised output, lags d_i by two clk_i edges
// ---------------------------------------------------------------------------
module sync2_bit (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pll_lock_reset_seq.sv
// ---------------------------------------------------------------------------
// pll_lock_reset_seq
// Sequencer between the PLL wrapper and the PLL-clocked logic. Pulses the
// PLL reset at power-on and on lock timeout, filters the synchronised lock,
// then releases downstream reset and raises ready in stages.
// Runs on the PLL reference clock.
// Ports:
//   clk_i            PLL reference clock
//   rst_n_i          synchronous active-low reset
//   lock_i           PLL lock, asynchronous
//   lock_lost_clr_i  single-cycle clear for lock_lost_o
//   pll_rst_o        PLL reset, active high
//   rst_out_n_o      downstream active-low reset, registered
//   ready_o          system up, registered
//   lock_lost_o      sticky: lock dropped while in RUN
//   loss_cnt_o       (PLL_LOCK_RESET_SEQ_LOSS_CNT_EN only) saturating count of
//                    RUN lock losses plus PLL reset retries
// Optional feature macro: PLL_LOCK_RESET_SEQ_LOSS_CNT_EN
// ---------------------------------------------------------------------------
module pll_lock_reset_seq
    import pll_seq_pkg::*;
#(
    parameter int unsigned LOCK_CYCLES    = DEF_LOCK_CYCLES,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int unsigned PLL_RST_CYCLES = DEF_PLL_RST_CYCLES,
    parameter int unsigned RELEASE_DELAY  = DEF_RELEASE_DELAY
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       lock_i,
    input  logic       lock_lost_clr_i,
    output logic       pll_rst_o,
    output logic       rst_out_n_o,
    output logic       ready_o,
    output logic       lock_lost_o
`ifdef PLL_LOCK_RESET_SEQ_LOSS_CNT_EN
    ,
    output logic [7:0] loss_cnt_o
`endif
);

    localparam int CW = cnt_width(LOCK_CYCLES, TIMEOUT_CYCLES, PLL_RST_CYCLES, RELEASE_DELAY);
    typedef logic [CW-1:0] cnt_t;

    localparam cnt_t PRST_LAST = cnt_t'(PLL_RST_CYCLES - 1);
    localparam cnt_t TO_LAST   = cnt_t'(TIMEOUT_CYCLES - 1);
    // The WAIT_LOCK cycle that first sees lock_s counts as the first filtered
    // cycle, so FILTER itself needs LOCK_CYCLES-1 more.
    localparam cnt_t FILT_LAST = cnt_t'((LOCK_CYCLES > 1) ? LOCK_CYCLES - 2 : 0);
    localparam cnt_t REL_LAST  = cnt_t'(RELEASE_DELAY - 1);
    localparam cnt_t CNT_MAX   = '1;

    state_e state_q, state_d;
    cnt_t   cnt_q, cnt_d;
    logic   pll_rst_q, pll_rst_d;
    logic   rst_out_n_q, rst_out_n_d;
    logic   ready_q, ready_d;
    logic   lock_lost_q, lock_lost_d;
    logic   lock_s;
    logic   loss_evt;

    sync2_bit u_lock_sync (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .d_i     (lock_i),
        .q_o     (lock_s)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q     <= ST_PLL_RST;
            cnt_q       <= '0;
            pll_rst_q   <= 1'b0;
            rst_out_n_q <= 1'b0;
            ready_q     <= 1'b0;
            lock_lost_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pll_rst_q   <= pll_rst_d;
            rst_out_n_q <= rst_out_n_d;
            ready_q     <= ready_d;
            lock_lost_q <= lock_lost_d;
        end
    end

    assign loss_evt = (state_q == ST_RUN) && !lock_s;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            // pll_rst is registered, so the pulse is timed from the first
            // cycle it is actually high.
            ST_PLL_RST:   if (pll_rst_q && cnt_q == PRST_LAST) state_d = ST_WAIT_LOCK;
            ST_WAIT_LOCK: begin
                if (lock_s)                state_d = (LOCK_CYCLES == 1) ? ST_RELEASE : ST_FILTER;
                else if (cnt_q == TO_LAST) state_d = ST_PLL_RST;
            end
            ST_FILTER: begin
                if (!lock_s)                 state_d = ST_WAIT_LOCK;
                else if (cnt_q == FILT_LAST) state_d = ST_RELEASE;
            end
            ST_RELEASE: begin
                if (!lock_s)                state_d = ST_WAIT_LOCK;
                else if (cnt_q == REL_LAST) state_d = ST_RUN;
            end
            ST_RUN:       if (!lock_s) state_d = ST_WAIT_LOCK;
            default:      state_d = ST_PLL_RST;
        endcase

        // Cleared on entry; also held at 0 in PLL_RST until pll_rst is up.
        if (state_d != state_q || (state_q == ST_PLL_RST && !pll_rst_q))
            cnt_d = '0;
        else if (cnt_q != CNT_MAX)
            cnt_d = cnt_q + cnt_t'(1);
        else
            cnt_d = cnt_q;

        pll_rst_d   = (state_d == ST_PLL_RST);
        rst_out_n_d = (state_d == ST_RELEASE) || (state_d == ST_RUN);
        ready_d     = (state_d == ST_RUN);

        // Set beats clear.
        if (loss_evt)             lock_lost_d = 1'b1;
        else if (lock_lost_clr_i) lock_lost_d = 1'b0;
        else                      lock_lost_d = lock_lost_q;
    end

    assign pll_rst_o   = pll_rst_q;
    assign rst_out_n_o = rst_out_n_q;
    assign ready_o     = ready_q;
    assign lock_lost_o = lock_lost_q;

`ifdef PLL_LOCK_RESET_SEQ_LOSS_CNT_EN
    logic       retry_evt;
    logic [7:0] loss_cnt_q;

    assign retry_evt = (state_q == ST_WAIT_LOCK) && (state_d == ST_PLL_RST);

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            loss_cnt_q <= 8'd0;
        end else if (loss_evt || retry_evt) begin
            if (loss_cnt_q != 8'hFF) loss_cnt_q <= loss_cnt_q + 8'd1;
        end else if (lock_lost_clr_i) begin
            loss_cnt_q <= 8'd0;
        end
    end

    assign loss_cnt_o = loss_cnt_q;
`endif

endmodule

// File: tb/tb_pll_lock_reset_seq.sv
// ---------------------------------------------------------------------------
// tb_pll_lock_reset_seq
// Directed bench for pll_lock_reset_seq with LOCK_CYCLES=16,
// TIMEOUT_CYCLES=64, PLL_RST_CYCLES=4, RELEASE_DELAY=8.
// Edge numbers in comments are posedges counted from the stimulus change,
// which is always applied 1 time unit after a posedge.
// ---------------------------------------------------------------------------
module tb_pll_lock_reset_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic lock = 1'b0;
    logic clr = 1'b0;
    logic pll_rst, rst_out_n, ready, lock_lost;
`ifdef PLL_LOCK_RESET_SEQ_LOSS_CNT_EN
    logic [7:0] loss_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pll_lock_reset_seq #(
        .LOCK_CYCLES    (16),
        .TIMEOUT_CYCLES (64),
        .PLL_RST_CYCLES (4),
        .RELEASE_DELAY  (8)
    ) dut (
        .clk_i           (clk),
        .rst_n_i         (rst_n),
        .lock_i          (lock),
        .lock_lost_clr_i (clr),
        .pll_rst_o       (pll_rst),
        .rst_out_n_o     (rst_out_n),
        .ready_o         (ready),
        .lock_lost_o     (lock_lost)
`ifdef PLL_LOCK_RESET_SEQ_LOSS_CNT_EN
        ,
        .loss_cnt_o      (loss_cnt)
`endif
    );

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; lock = 1'b0; clr = 1'b0;
        step(3);
        checks++;
        if ({pll_rst, rst_out_n, ready, lock_lost} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_outputs: got %b want 0000", {pll_rst, rst_out_n, ready, lock_lost});
        end
    endtask

    task automatic test_power_on();
        int highs = 0;
        rst_n = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            step(1);
            if (pll_rst === 1'b1) highs++;
            if (e == 1) begin
                checks++;
                if (pll_rst !== 1'b1) begin errors++; $display("FAIL por_pll_rise: got %b want 1", pll_rst); end
            end
            if (e == 5) begin
                checks++;
                if (pll_rst !== 1'b0) begin errors++; $display("FAIL por_pll_fall: got %b want 0", pll_rst); end
            end
        end
        checks++;
        if (highs != 4) begin errors++; $display("FAIL por_pll_width: got %0d want 4", highs); end
        lock = 1'b1;
        step(17); // edge 17 after lock
        checks++;
        if (rst_out_n !== 1'b0) begin errors++; $display("FAIL por_rst_early: got %b want 0", rst_out_n); end
        step(1);  // edge 18
        checks++;
        if ({rst_out_n, ready} !== 2'b10) begin errors++; $display("FAIL por_rst_rise: got %b want 10", {rst_out_n, ready}); end
        step(7);
        checks++;
        if (ready !== 1'b0) begin errors++; $display("FAIL por_ready_early: got %b want 0", ready); end
        step(1);  // 8 after rst_out_n
        checks++;
        if ({ready, pll_rst, lock_lost} !== 3'b100) begin
            errors++; $display("FAIL por_ready_rise: got %b want 100", {ready, pll_rst, lock_lost});
        end
    endtask

    task automatic test_lock_loss();
        logic pll_seen = 1'b0;
        lock = 1'b0;
        step(2);
        checks++;
        if (rst_out_n !== 1'b1) begin errors++; $display("FAIL loss_early: got %b want 1", rst_out_n); end
        step(1);  // edge 3
        checks++;
        if ({rst_out_n, ready, lock_lost, pll_rst} !== 4'b0010) begin
            errors++; $display("FAIL loss_drop: got %b want 0010", {rst_out_n, ready, lock_lost, pll_rst});
        end
        lock = 1'b1;
        for (int e = 4; e <= 20; e++) begin
            step(1);
            pll_seen |= pll_rst;
        end
        checks++;
        if (rst_out_n !== 1'b0) begin errors++; $display("FAIL loss_rerelease_early: got %b want 0", rst_out_n); end
        step(1);  // 18 after re-raise
        checks++;
        if (rst_out_n !== 1'b1) begin errors++; $display("FAIL loss_rerelease: got %b want 1", rst_out_n); end
        step(8);
        checks++;
        if ({ready, lock_lost, pll_seen} !== 3'b110) begin
            errors++; $display("FAIL loss_ready_sticky_nopll: got %b want 110", {ready, lock_lost, pll_seen});
        end
    endtask

    task automatic test_sticky_clear();
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        checks++;
        if (lock_lost !== 1'b0) begin errors++; $display("FAIL clr_alone: got %b want 0", lock_lost); end
        lock = 1'b0;
        step(2);
        clr = 1'b1;   // coincides with the loss event on edge 3
        step(1);
        clr = 1'b0;
        checks++;
        if ({lock_lost, rst_out_n} !== 2'b10) begin
            errors++; $display("FAIL clr_vs_set: got %b want 10", {lock_lost, rst_out_n});
        end
        lock = 1'b1;
        step(26);
        checks++;
        if (ready !== 1'b1) begin errors++; $display("FAIL clr_recover_ready: got %b want 1", ready); end
    endtask

    task automatic test_glitch();
        int rises = 0;
        lock = 1'b0;
        step(3);
        checks++;
        if (rst_out_n !== 1'b0) begin errors++; $display("FAIL glitch_setup: got %b want 0", rst_out_n); end
        lock = 1'b1;
        step(10);
        lock = 1'b0;
        step(1);
        lock = 1'b1;  // re-rise after edge 14
        for (int e = 15; e <= 31; e++) begin
            step(1);
            if (rst_out_n !== 1'b0) rises++;
        end
        checks++;
        if (rises != 0) begin errors++; $display("FAIL glitch_no_edge: got %0d high cycles want 0", rises); end
        step(1);      // edge 32 = 18 after re-rise
        checks++;
        if (rst_out_n !== 1'b1) begin errors++; $display("FAIL glitch_release: got %b want 1", rst_out_n); end
        step(8);
        checks++;
        if (ready !== 1'b1) begin errors++; $display("FAIL glitch_ready: got %b want 1", ready); end
    endtask

    task automatic test_timeout();
        logic exp_pll, exp_up;
        lock = 1'b0;
        for (int e = 1; e <= 140; e++) begin
            step(1);
            exp_pll = (e >= 67 && e <= 70) || (e >= 135 && e <= 138);
            exp_up  = (e < 3);
            checks++;
            if ({pll_rst, rst_out_n, ready} !== {exp_pll, exp_up, exp_up}) begin
                errors++;
                $display("FAIL timeout_edge%0d: got %b want %b", e, {pll_rst, rst_out_n, ready}, {exp_pll, exp_up, exp_up});
            end
        end
    endtask

    task automatic test_reset_mid();
        int highs = 0;
        lock = 1'b1;
        step(5);      // FILTER
        checks++;
        if ({lock_lost, rst_out_n} !== 2'b10) begin
            errors++; $display("FAIL mid_pre: got %b want 10", {lock_lost, rst_out_n});
        end
        rst_n = 1'b0;
        step(1);
        checks++;
        if ({pll_rst, rst_out_n, ready, lock_lost} !== 4'b0000) begin
            errors++; $display("FAIL mid_reset: got %b want 0000", {pll_rst, rst_out_n, ready, lock_lost});
        end
`ifdef PLL_LOCK_RESET_SEQ_LOSS_CNT_EN
        checks++;
        if (loss_cnt !== 8'd0) begin errors++; $display("FAIL mid_loss_cnt: got %0d want 0", loss_cnt); end
`endif
        step(1);
        rst_n = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            step(1);
            if (pll_rst === 1'b1) highs++;
            if (e == 1) begin
                checks++;
                if (pll_rst !== 1'b1) begin errors++; $display("FAIL mid_por_rise: got %b want 1", pll_rst); end
            end
        end
        checks++;
        if ({highs == 4, rst_out_n} !== 2'b10) begin
            errors++; $display("FAIL mid_por: got highs %0d rst %b want 4 0", highs, rst_out_n);
        end
        step(1);      // edge 21
        checks++;
        if (rst_out_n !== 1'b1) begin errors++; $display("FAIL mid_rerelease: got %b want 1", rst_out_n); end
    endtask

`ifdef PLL_LOCK_RESET_SEQ_LOSS_CNT_EN
    task automatic test_loss_cnt();
        rst_n = 1'b0; lock = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(68);
        checks++;
        if (loss_cnt !== 8'd0) begin errors++; $display("FAIL cnt_before_retry: got %0d want 0", loss_cnt); end
        step(1);      // first retry at edge 69
        checks++;
        if (loss_cnt !== 8'd1) begin errors++; $display("FAIL cnt_first_retry: got %0d want 1", loss_cnt); end
        step(68 * 259);
        checks++;
        if (loss_cnt !== 8'd255) begin errors++; $display("FAIL cnt_saturate: got %0d want 255", loss_cnt); end
        step(67);
        clr = 1'b1;   // coincides with the next retry
        step(1);
        clr = 1'b0;
        checks++;
        if (loss_cnt !== 8'd255) begin errors++; $display("FAIL cnt_inc_vs_clr: got %0d want 255", loss_cnt); end
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        checks++;
        if (loss_cnt !== 8'd0) begin errors++; $display("FAIL cnt_clr: got %0d want 0", loss_cnt); end
    endtask
`endif

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_power_on();
        test_lock_loss();
        test_sticky_clear();
        test_glitch();
        test_timeout();
        test_reset_mid();
`ifdef PLL_LOCK_RESET_SEQ_LOSS_CNT_EN
        test_loss_cnt();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
